audio_recorder: RTL and testbench
=================================

AUDIO_RECORDER -- requirements
Module: audio_recorder

Interface
REQ-001 SHALL have parameter ADDR_MAX, default 20'hFFFFF, last writable SRAM word address.
REQ-002 SHALL have port i_clk  input  1  codec bit clock (BCLK); all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_lrc  input  1  codec ADCLRC; 0 = left channel frame.
REQ-005 SHALL have port i_data  input  1  codec ADCDAT serial sample bit.
REQ-006 SHALL have port i_start  input  1  level; begin or resume recording.
REQ-007 SHALL have port i_pause  input  1  level; suspend recording, keep address.
REQ-008 SHALL have port i_stop  input  1  level; end recording.
REQ-009 SHALL have port o_address  output  20  SRAM word address of the current/next write.
REQ-010 SHALL have port o_data  output  16  captured left-channel sample, two's complement.
REQ-011 SHALL have port o_valid  output  1  one-cycle SRAM write strobe for o_address/o_data.
REQ-012 SHALL have port o_full  output  1  one-cycle pulse when recording ends on ADDR_MAX.

Function
REQ-013 SHALL implement states S_IDLE, S_WAIT, S_DELAY, S_SHIFT, S_SAVE, S_PAUSE.
REQ-014 SHALL register i_lrc each cycle (lrc_prev); LRC falling edge = lrc_prev 1 and i_lrc 0.
REQ-015 S_IDLE: on i_start, SHALL clear o_address to 0 and go to S_WAIT.
REQ-016 S_WAIT: on LRC falling edge, SHALL go to S_DELAY (that edge is the I2S delay bit, discarded).
REQ-017 S_DELAY/S_SHIFT: SHALL shift i_data in MSB first on 16 consecutive edges, then go to S_SAVE.
REQ-018 S_SAVE: SHALL drive o_valid=1 for exactly one cycle with o_data = the 16 bits, MSB = first shifted bit.
REQ-019 Latency: o_valid SHALL be high in the cycle after the 16th data bit is sampled (LRC fall edge k, bits on k+1..k+16, o_valid during cycle after k+16).
REQ-020 After S_SAVE, o_address SHALL increment by 1 and state SHALL return to S_WAIT; right-channel frames are ignored.
REQ-021 o_data and o_address SHALL stay stable while o_valid is high and hold their values otherwise.
REQ-022 i_pause in S_WAIT/S_DELAY/S_SHIFT SHALL abort any partial sample (no o_valid) and go to S_PAUSE; o_address unchanged.
REQ-023 S_PAUSE: i_start SHALL go to S_WAIT without clearing o_address.
REQ-024 i_stop in any state SHALL go to S_IDLE next cycle; a partial sample is discarded; o_address held.
REQ-025 Simultaneous events: stop beats pause, pause beats start; a pending S_SAVE strobe SHALL still complete if stop/pause arrives in that cycle.
REQ-026 i_start while already recording SHALL be ignored.
REQ-027 Full: after the write at o_address == ADDR_MAX, behaviour SHALL follow Configuration.

Reset
REQ-028 On i_rst_n low, state SHALL be S_IDLE, o_address 0, o_data 0, o_valid 0, o_full 0, lrc_prev 1, shift register 0.
REQ-029 Reset mid-capture SHALL discard the sample and produce no o_valid.

Configuration
REQ-030 Macro REC_WRAP_EN SHALL select full behaviour.
REQ-031 Without REC_WRAP_EN: after the write at ADDR_MAX, o_full SHALL pulse one cycle, o_address SHALL hold ADDR_MAX, state SHALL go to S_IDLE.
REQ-032 With REC_WRAP_EN: o_address SHALL wrap from ADDR_MAX to 0, recording continues, and o_full SHALL pulse one cycle per wrap.

Verification
REQ-033 Reset, i_start, left frame data 16'hA5C3 after delay bit -> one o_valid, o_data 16'hA5C3, o_address 0, then o_address 1.
REQ-034 Three left frames 16'h0001, 16'h8000, 16'hFFFF -> o_valid x3 at addresses 0,1,2 with those values; right-frame data never written.
REQ-035 i_pause asserted at 8th bit of frame 2 -> no o_valid for frame 2; i_start -> next frame written at address 1.
REQ-036 i_stop and i_start high together mid-shift -> S_IDLE, no o_valid; later i_start -> writes at address 0.
REQ-037 ADDR_MAX=3, four frames: without REC_WRAP_EN -> writes 0..3, o_full pulse, fifth frame ignored; with REC_WRAP_EN -> fifth frame at address 0.
REQ-038 i_rst_n low at bit 10 of a frame -> all outputs 0 immediately, no o_valid after release until i_start.

Source files
------------

// File: rtl/audio_recorder.sv
// audio_recorder: captures left-channel I2S samples from a codec and emits
// one SRAM write strobe per sample at an auto-incrementing word address.
// Optional feature macro REC_WRAP_EN: when defined, the address wraps from
// ADDR_MAX to 0 and recording continues; when undefined, recording stops
// after the write at ADDR_MAX.
module audio_recorder #(
  parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lrc,
  input  logic        i_data,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  output logic [19:0] o_address,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_full
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

`ifdef REC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DELAY, S_SHIFT, S_SAVE, S_PAUSE
  } state_t;

  state_t          state, state_next;
  logic            lrc_prev;
  logic [DW-1:0]   shift_q;
  logic [CW-1:0]   bit_cnt;
  logic            lrc_fall;
  logic            at_max;
  logic            addr_clr, cnt_clr, shift_en, capture, advance;

  assign lrc_fall = lrc_prev & ~i_lrc;
  assign at_max   = (o_address == AW'(ADDR_MAX));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and datapath control; stop beats pause beats start
  always_comb begin
    state_next = state;
    addr_clr   = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start && !i_stop && !i_pause) begin
          state_next = S_WAIT;
          addr_clr   = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_stop)        state_next = S_IDLE;
        else if (i_pause)  state_next = S_PAUSE;
        else if (lrc_fall) begin
          state_next = S_DELAY;
          cnt_clr    = 1'b1;
        end
      end
      S_DELAY: begin
        if (i_stop)       state_next = S_IDLE;
        else if (i_pause) state_next = S_PAUSE;
        else begin
          shift_en   = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_stop)       state_next = S_IDLE;
        else if (i_pause) state_next = S_PAUSE;
        else begin
          shift_en = 1'b1;
          if (bit_cnt == CW'(DW - 1)) begin
            capture    = 1'b1;
            state_next = S_SAVE;
          end
        end
      end
      S_SAVE: begin
        // The strobe is already out; the write completes even on stop/pause
        advance = 1'b1;
        if (i_stop)                 state_next = S_IDLE;
        else if (i_pause)           state_next = S_PAUSE;
        else if (at_max && !WRAP)   state_next = S_IDLE;
        else                        state_next = S_WAIT;
      end
      S_PAUSE: begin
        if (i_stop)       state_next = S_IDLE;
        else if (i_start) state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // LRC edge tracking, sample shifter and bit counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_prev <= 1'b1;
      shift_q  <= '0;
      bit_cnt  <= '0;
    end else begin
      lrc_prev <= i_lrc;
      if (shift_en) shift_q <= {shift_q[DW-2:0], i_data};
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Registered SRAM write interface and full indication
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_address <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_full    <= 1'b0;
    end else begin
      o_valid <= capture;
      o_full  <= advance & at_max;
      if (capture) o_data <= {shift_q[DW-2:0], i_data};
      if (addr_clr) begin
        o_address <= '0;
      end else if (advance) begin
        if (!at_max)   o_address <= o_address + AW'(1);
        else if (WRAP) o_address <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Directed testbench for audio_recorder (instantiated with ADDR_MAX = 3).
module tb_audio_recorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrc = 1'b1;
  logic        sdata = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] address;
  logic [15:0] data;
  logic        valid;
  logic        full;

  int total = 0;
  int bad = 0;

  // Write log filled by the monitor; tests snapshot wr_n before running
  logic [19:0] wa [0:63];
  logic [15:0] wd [0:63];
  int          wr_n = 0;
  int          full_n = 0;

  audio_recorder #(.ADDR_MAX(20'd3)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_lrc     (lrc),
    .i_data    (sdata),
    .i_start   (start),
    .i_pause   (pause),
    .i_stop    (stop),
    .o_address (address),
    .o_data    (data),
    .o_valid   (valid),
    .o_full    (full)
  );

  always #5 clk = ~clk;

  // Record every write strobe and full pulse away from the active edge
  always @(negedge clk) begin
    if (valid && wr_n < 64) begin
      wa[wr_n] = address;
      wd[wr_n] = data;
    end
    if (valid) wr_n = wr_n + 1;
    if (full)  full_n = full_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic l, input logic d);
    @(negedge clk);
    lrc = l;
    sdata = d;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One I2S frame: delay bit then 16 bits MSB first in each half.
  // ev_kind: 0 none, 1 pause, 2 stop+start, 3 reset, applied at left bit ev_bit.
  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int ev_kind, input int ev_bit);
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, (i >= 1 && i <= 16) ? l[16-i] : 1'b0);
      pause = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      if (ev_kind == 3 && i == ev_bit + 1) rst_n = 1'b1;
      if (i == ev_bit) begin
        if (ev_kind == 1) pause = 1'b1;
        if (ev_kind == 2) begin
          stop  = 1'b1;
          start = 1'b1;
        end
        if (ev_kind == 3) begin
          rst_n = 1'b0;
          #1;
          check("rst_addr", 32'(address), 32'h0);
          check("rst_data", 32'(data), 32'h0);
          check("rst_valid", 32'(valid), 32'h0);
          check("rst_full", 32'(full), 32'h0);
        end
      end
    end
    for (int i = 0; i < 32; i++)
      tick(1'b1, (i >= 1 && i <= 16) ? r[16-i] : 1'b0);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_addr", 32'(address), 32'h0);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_full", 32'(full), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single left sample
    base = wr_n;
    pulse_start();
    frame(16'hA5C3, 16'hDEAD, 0, -1);
    check("t1_count", 32'(wr_n - base), 32'd1);
    check("t1_addr", 32'(wa[base]), 32'd0);
    check("t1_data", 32'(wd[base]), 32'hA5C3);
    check("t1_next_addr", 32'(address), 32'd1);

    // Three frames, right channel ignored
    do_reset();
    base = wr_n;
    pulse_start();
    frame(16'h0001, 16'hDEAD, 0, -1);
    frame(16'h8000, 16'hBEEF, 0, -1);
    frame(16'hFFFF, 16'h1234, 0, -1);
    check("t2_count", 32'(wr_n - base), 32'd3);
    check("t2_addr0", 32'(wa[base]), 32'd0);
    check("t2_data0", 32'(wd[base]), 32'h0001);
    check("t2_addr1", 32'(wa[base+1]), 32'd1);
    check("t2_data1", 32'(wd[base+1]), 32'h8000);
    check("t2_addr2", 32'(wa[base+2]), 32'd2);
    check("t2_data2", 32'(wd[base+2]), 32'hFFFF);
    check("t2_next_addr", 32'(address), 32'd3);

    // Pause mid-sample, resume
    do_reset();
    base = wr_n;
    pulse_start();
    frame(16'h1111, 16'hDEAD, 0, -1);
    frame(16'h2222, 16'hDEAD, 1, 8);
    check("t3_after_pause", 32'(wr_n - base), 32'd1);
    pulse_start();
    frame(16'h3333, 16'hDEAD, 0, -1);
    check("t3_count", 32'(wr_n - base), 32'd2);
    check("t3_addr", 32'(wa[base+1]), 32'd1);
    check("t3_data", 32'(wd[base+1]), 32'h3333);

    // Stop with start mid-shift
    do_reset();
    base = wr_n;
    pulse_start();
    frame(16'h4444, 16'hDEAD, 2, 5);
    check("t4_after_stop", 32'(wr_n - base), 32'd0);
    pulse_start();
    frame(16'h5555, 16'hDEAD, 0, -1);
    check("t4_count", 32'(wr_n - base), 32'd1);
    check("t4_addr", 32'(wa[base]), 32'd0);
    check("t4_data", 32'(wd[base]), 32'h5555);

    // Full at ADDR_MAX = 3
    do_reset();
    base = wr_n;
    full_n = 0;
    pulse_start();
    for (int f = 0; f < 5; f++)
      frame(16'h0010 + 16'(f), 16'hDEAD, 0, -1);
    check("t5_full", 32'(full_n), 32'd1);
    check("t5_addr3", 32'(wa[base+3]), 32'd3);
    check("t5_data3", 32'(wd[base+3]), 32'h0013);
`ifdef REC_WRAP_EN
    check("t5_count", 32'(wr_n - base), 32'd5);
    check("t5_wrap_addr", 32'(wa[base+4]), 32'd0);
    check("t5_wrap_data", 32'(wd[base+4]), 32'h0014);
    check("t5_next_addr", 32'(address), 32'd1);
`else
    check("t5_count", 32'(wr_n - base), 32'd4);
    check("t5_hold_addr", 32'(address), 32'd3);
`endif

    // Reset mid-capture
    do_reset();
    pulse_start();
    base = wr_n;
    frame(16'h6666, 16'hDEAD, 3, 10);
    frame(16'h6767, 16'hDEAD, 0, -1);
    check("t6_no_write", 32'(wr_n - base), 32'd0);
    check("t6_addr", 32'(address), 32'd0);
    pulse_start();
    frame(16'h7777, 16'hDEAD, 0, -1);
    check("t6_count", 32'(wr_n - base), 32'd1);
    check("t6_w_addr", 32'(wa[base]), 32'd0);
    check("t6_w_data", 32'(wd[base]), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
